// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline hazard/stall control slice.
package arm_pipe_pkg;

  localparam int REG_W_DEF = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  // EX-stage control word; a bubble loads NOP_CTRL so the slot has no side effects.
  typedef struct packed {
    logic wb_en;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ex_ctrl_t;

  localparam ex_ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/hazard_compare.sv
// Combinational RAW comparison of the ID-stage sources against the EX and MEM destinations.
module hazard_compare
  import arm_pipe_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] i_id_rn,
  input  logic [REG_W-1:0] i_id_rm,
  input  logic             i_id_two_src,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_ex_dest,
  input  logic             i_ex_wb_en,
  input  logic [REG_W-1:0] i_mem_dest,
  input  logic             i_mem_wb_en,
  output logic             o_hit_ex,
  output logic             o_hit_mem
);

  logic w_ex_match;
  logic w_mem_match;

  assign w_ex_match  = (i_ex_dest == i_id_rn)  || (i_id_two_src && (i_ex_dest == i_id_rm));
  assign w_mem_match = (i_mem_dest == i_id_rn) || (i_id_two_src && (i_mem_dest == i_id_rm));

  assign o_hit_ex  = i_id_valid && i_ex_wb_en  && w_ex_match;
  assign o_hit_mem = i_id_valid && i_mem_wb_en && w_mem_match;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline with memory wait FSM and debug counters.
// Build option: define PIPELINE_FORWARDING_EN to stall only on load-use hazards.
module pipeline_hazard_controller
  import arm_pipe_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_two_src,
  input  logic             id_valid,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_front,
  output logic             bubble_id,
  output logic             flush,
  output logic             freeze_all,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = 16;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_error;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_hit_ex;
  logic w_hit_mem;
  logic w_run;
  logic w_hazard_raw;
  logic w_hazard;
  logic w_freeze_all;
  logic w_freeze_front;
  logic w_flush;
  logic w_unused_sig;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hazard_compare #(.REG_W(REG_W)) u_hazard_compare (
    .i_id_rn      (id_rn),
    .i_id_rm      (id_rm),
    .i_id_two_src (id_two_src),
    .i_id_valid   (id_valid),
    .i_ex_dest    (ex_dest),
    .i_ex_wb_en   (ex_wb_en),
    .i_mem_dest   (mem_dest),
    .i_mem_wb_en  (mem_wb_en),
    .o_hit_ex     (w_hit_ex),
    .o_hit_mem    (w_hit_mem)
  );

`ifdef PIPELINE_FORWARDING_EN
  // ALU results are forwarded; only a load in EX cannot be bypassed in time.
  assign w_hazard_raw = w_hit_ex && ex_mem_read;
`else
  assign w_hazard_raw = w_hit_ex || w_hit_mem;
`endif
  assign w_unused_sig = ex_mem_read ^ w_hit_mem;

  assign w_run          = (r_state == RUN);
  // Combinational so the very first wait cycle is already frozen.
  assign w_freeze_all   = !w_run || (mem_req && !mem_ready);
  assign w_hazard       = w_run && w_hazard_raw;
  assign w_flush        = branch_taken && !w_freeze_all;
  assign w_freeze_front = w_hazard && !branch_taken && !w_freeze_all;

  assign freeze_front = w_freeze_front;
  assign bubble_id    = w_freeze_front;
  assign flush        = w_flush;
  assign freeze_all   = w_freeze_all;
  assign mem_error    = r_mem_error;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_mem_error <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            r_state     <= ERROR;
            r_mem_error <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ERROR: begin
          r_mem_error <= 1'b1;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_freeze_front) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_flush)        r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed and randomized bench for pipeline_hazard_controller against a behavioural model.
module tb_pipeline_hazard_controller;

  localparam int REG_W = 4;
  localparam int CNT_W = 4;
  localparam int TMO   = 5;
  localparam int CMAX  = (1 << CNT_W) - 1;

`ifdef PIPELINE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [REG_W-1:0] id_rn, id_rm, ex_dest, mem_dest;
  logic             id_two_src, id_valid, ex_wb_en, ex_mem_read, mem_wb_en;
  logic             branch_taken, mem_req, mem_ready;
  logic             freeze_front, bubble_id, flush, freeze_all, mem_error;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: outstanding access tracking and event totals.
  bit m_busy;
  bit m_err;
  int m_unready;
  int m_stalls;
  int m_flushes;
  bit e_fa, e_ff, e_fl;

  pipeline_hazard_controller #(
    .REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rn(id_rn), .id_rm(id_rm), .id_two_src(id_two_src), .id_valid(id_valid),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_front(freeze_front), .bubble_id(bubble_id), .flush(flush),
    .freeze_all(freeze_all), .mem_error(mem_error),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic bit reads(input logic [REG_W-1:0] d);
    return (d == id_rn) || (id_two_src && (d == id_rm));
  endfunction

  task automatic clear_in();
    id_rn = '0; id_rm = '0; id_two_src = 0; id_valid = 0;
    ex_dest = '0; ex_wb_en = 0; ex_mem_read = 0;
    mem_dest = '0; mem_wb_en = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_unready = 0; m_stalls = 0; m_flushes = 0;
  endtask

  // Settle the current inputs and compare every output with the model.
  task automatic eval();
    bit hex, hmem, haz, idle;
    #1;
    idle = !m_busy && !m_err;
    hex  = id_valid && ex_wb_en && reads(ex_dest);
    hmem = id_valid && mem_wb_en && reads(mem_dest);
    haz  = FWD ? (hex && ex_mem_read) : (hex || hmem);
    e_fa = !idle || (mem_req && !mem_ready);
    e_ff = idle && haz && !branch_taken && !e_fa;
    e_fl = branch_taken && !e_fa;
    chk("freeze_all",   32'(freeze_all),   32'(e_fa));
    chk("freeze_front", 32'(freeze_front), 32'(e_ff));
    chk("bubble_id",    32'(bubble_id),    32'(e_ff));
    chk("flush",        32'(flush),        32'(e_fl));
    chk("mem_error",    32'(mem_error),    32'(m_err));
    chk("stall_cnt",    32'(stall_cnt),    32'(sat(m_stalls)));
    chk("flush_cnt",    32'(flush_cnt),    32'(sat(m_flushes)));
  endtask

  // Advance the model across one rising edge, then return at the next falling edge.
  task automatic tick();
    if (e_ff) m_stalls++;
    if (e_fl) m_flushes++;
    if (m_busy) begin
      if (mem_ready) m_busy = 0;
      else begin
        m_unready++;
        if (m_unready > TMO) begin m_busy = 0; m_err = 1; end
      end
    end else if (!m_err && mem_req && !mem_ready) begin
      m_busy = 1; m_unready = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_freeze_all",   32'(freeze_all),   32'd0);
    chk("rst_freeze_front", 32'(freeze_front), 32'd0);
    chk("rst_flush",        32'(flush),        32'd0);
    chk("rst_mem_error",    32'(mem_error),    32'd0);
    chk("rst_stall_cnt",    32'(stall_cnt),    32'd0);
    chk("rst_flush_cnt",    32'(flush_cnt),    32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    model_reset();
    @(negedge clk);
    do_reset();

    // EX-stage RAW on Rn
    ex_wb_en = 1; ex_dest = 4'd3; id_rn = 4'd3; id_valid = 1;
    eval();
    chk("ex_hit_ff", 32'(freeze_front), FWD ? 32'd0 : 32'd1);
    tick();
    clear_in();
    eval();
    chk("ex_hit_cnt", 32'(stall_cnt), FWD ? 32'd0 : 32'd1);
    tick();

    // Load-use always stalls
    ex_wb_en = 1; ex_dest = 4'd3; id_rn = 4'd3; id_valid = 1; ex_mem_read = 1;
    eval();
    chk("load_use_ff", 32'(freeze_front), 32'd1);
    tick();
    clear_in();

    // Rm only compared when the instruction reads it
    mem_wb_en = 1; mem_dest = 4'd5; id_rm = 4'd5; id_rn = 4'd0; id_valid = 1;
    eval();
    chk("rm_ignored", 32'(freeze_front), 32'd0);
    tick();
    id_two_src = 1;
    eval();
    chk("rm_used", 32'(freeze_front), FWD ? 32'd0 : 32'd1);
    tick();
    clear_in();

    // Branch beats hazard
    ex_wb_en = 1; ex_dest = 4'd7; id_rn = 4'd7; id_valid = 1; ex_mem_read = 1;
    branch_taken = 1;
    eval();
    chk("br_flush", 32'(flush), 32'd1);
    chk("br_noff",  32'(freeze_front), 32'd0);
    tick();
    clear_in();
    eval();
    chk("br_cnt", 32'(flush_cnt), 32'd1);
    tick();

    // Three unready cycles then ready; held branch flushes after the freeze
    mem_req = 1; mem_ready = 0; branch_taken = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) mem_req = 0;
      mem_ready = (i == 3);
      eval();
      chk("wait_fa", 32'(freeze_all), 32'd1);
      chk("wait_nofl", 32'(flush), 32'd0);
      tick();
    end
    mem_ready = 0;
    eval();
    chk("wait_done_fa", 32'(freeze_all), 32'd0);
    chk("wait_done_fl", 32'(flush), 32'd1);
    chk("wait_done_err", 32'(mem_error), 32'd0);
    tick();
    clear_in();

    // Zero-wait access
    mem_req = 1; mem_ready = 1;
    eval();
    chk("zw_fa", 32'(freeze_all), 32'd0);
    tick();
    clear_in();
    eval();
    chk("zw_fa_next", 32'(freeze_all), 32'd0);
    tick();

    // Stall counter saturation
    ex_wb_en = 1; ex_dest = 4'd2; id_rn = 4'd2; id_valid = 1; ex_mem_read = 1;
    for (int i = 0; i < CMAX + 4; i++) begin eval(); tick(); end
    clear_in();
    eval();
    chk("stall_sat", 32'(stall_cnt), 32'(CMAX));
    tick();

    // Timeout into ERROR, held until reset
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i <= TMO; i++) begin
      eval();
      chk("tmo_pending_err", 32'(mem_error), 32'd0);
      tick();
      mem_req = 0;
    end
    eval();
    chk("tmo_err", 32'(mem_error), 32'd1);
    chk("tmo_fa",  32'(freeze_all), 32'd1);
    tick();
    mem_ready = 1; branch_taken = 1;
    eval();
    chk("err_held", 32'(mem_error), 32'd1);
    chk("err_fa_held", 32'(freeze_all), 32'd1);
    tick();
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      id_rn        = REG_W'($urandom_range(0, 3));
      id_rm        = REG_W'($urandom_range(0, 3));
      ex_dest      = REG_W'($urandom_range(0, 3));
      mem_dest     = REG_W'($urandom_range(0, 3));
      id_two_src   = 1'($urandom_range(0, 1));
      id_valid     = ($urandom_range(0, 9) < 8);
      ex_wb_en     = 1'($urandom_range(0, 1));
      ex_mem_read  = 1'($urandom_range(0, 1));
      mem_wb_en    = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 99) < 15);
      mem_req      = ($urandom_range(0, 9) == 0);
      mem_ready    = ($urandom_range(0, 9) < 4);
      eval();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
